ram_dump_controller: RTL

Read-side counterpart to the RAM's manual programming path. On a start pulse it takes ownership of the RAM address lines and walks all 16 locations from address 0 to 15, capturing each word from the RAM's combinational data output. It transmits each word over a UART line (8N1, LSB first) so the loaded program can be checked on a host. It sits beside the RAM and the memory address register, and drives the RAM address mux only while `mem_select` is high.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/ram_dump_controller_if.sv | 37 +++
 rtl/uart_tx_byte.sv | 68 ++++++
 rtl/ram_dump_controller.sv | 91 +++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-side widths and the RAM dump controller state encoding.
// Latency: none (declarations only).
// Backpressure: not applicable.
package cpu_pkg;

    // RAM and memory address register widths.
    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;

    // One UART 8N1 frame: start bit, eight data bits, stop bit.
    localparam int FRAME_BITS = 10;

    // Dump sequencer states. The START / DATA / STOP phases of each word
    // live inside uart_tx_byte; the sequencer waits in DS_SEND for them.
    // The step to the next word is folded into the last stop cycle, so it
    // has no state of its own.
    typedef enum logic [2:0] {
        DS_IDLE   = 3'd0,
        DS_ADDR   = 3'd1,
        DS_LOAD   = 3'd2,
        DS_SEND   = 3'd3,
        DS_FINISH = 3'd4
    } dump_state_t;

endpackage

// File: rtl/ram_dump_controller_if.sv
// Bundle between the dump controller, the RAM read port and the UART pin.
// Latency: none (wiring only).
// Backpressure: none; start is a request pulse, busy/done report progress.
interface ram_dump_controller_if;
    import cpu_pkg::*;

    logic              start;
    logic              mem_select;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data;
    logic              tx;
    logic              busy;
    logic              done;

    // Controller side.
    modport master (
        input  start,
        input  mem_data,
        output mem_select,
        output mem_address,
        output tx,
        output busy,
        output done
    );

    // Requester / RAM / host side.
    modport slave (
        output start,
        output mem_data,
        input  mem_select,
        input  mem_address,
        input  tx,
        input  busy,
        input  done
    );

endinterface

// File: rtl/uart_tx_byte.sv
// Serialises one byte as an 8N1 UART frame, LSB first, on a registered tx pin.
// Latency: tx drops for the start bit at the edge that samples load; frame lasts 10*CLKS_PER_BIT cycles.
// Backpressure: busy is low only when a new load can be taken at the coming edge (idle or final stop cycle).
module uart_tx_byte
    import cpu_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] data,
    output logic              tx,
    output logic              busy
);

    localparam int                CNT_W      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]        LAST_BIT   = 4'(FRAME_BITS - 1);

    logic              active;
    logic [CNT_W-1:0]  baud_cnt;
    logic [3:0]        bit_idx;
    // Bits still to be shifted out after the one on tx: data then stop.
    logic [DATA_W:0]   pending;
    logic              bit_end;
    logic              last_cycle;

    assign bit_end    = active && (baud_cnt == '0);
    assign last_cycle = bit_end && (bit_idx == LAST_BIT);

    // Busy drops during the final stop cycle so the next word can follow
    // without an extra idle cycle; the caller never loads sooner anyway.
    assign busy = active && !last_cycle;

    // Baud counter, bit index and shift register; reload at each bit boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active   <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            pending  <= '1;
            tx       <= 1'b1;
        end else if (load) begin
            active   <= 1'b1;
            baud_cnt <= CNT_RELOAD;
            bit_idx  <= '0;
            pending  <= {1'b1, data};
            tx       <= 1'b0;
        end else if (active) begin
            if (baud_cnt == '0) begin
                baud_cnt <= CNT_RELOAD;
                if (bit_idx == LAST_BIT) begin
                    active  <= 1'b0;
                    bit_idx <= '0;
                    tx      <= 1'b1;
                end else begin
                    bit_idx <= bit_idx + 4'd1;
                    tx      <= pending[0];
                    pending <= {1'b1, pending[DATA_W:1]};
                end
            end else begin
                baud_cnt <= baud_cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_dump_controller.sv
// Walks RAM addresses 0..NUM_WORDS-1 and streams each word out over UART 8N1.
// Latency: first start bit two cycles after start is sampled; 2+10*CLKS_PER_BIT cycles per word.
// Backpressure: start is ignored while busy; nothing is queued.
module ram_dump_controller
    import cpu_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,   // must be >= 2
    parameter int NUM_WORDS    = 16     // must not exceed 2**ADDR_W
) (
    input  logic                    clk,
    input  logic                    rst,
    ram_dump_controller_if.master   bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

    dump_state_t state;
    dump_state_t state_nxt;

    logic uart_load;
    logic uart_busy;
    logic last_word;
    logic word_done;
    logic sel_nxt;
    logic done_nxt;

    assign last_word = (bus.mem_address == LAST_ADDR);
    // The serialiser is in its final stop cycle: this is the folded NEXT step.
    assign word_done = (state == DS_SEND) && !uart_busy;

    // State register plus registered copies of the status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= DS_IDLE;
            bus.mem_select <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
        end else begin
            state          <= state_nxt;
            bus.mem_select <= sel_nxt;
            bus.busy       <= sel_nxt;
            bus.done       <= done_nxt;
        end
    end

    // Address sequencing: clear on an accepted start, step once per finished word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.mem_address <= '0;
        end else if ((state == DS_IDLE) && bus.start) begin
            bus.mem_address <= '0;
        end else if (word_done && !last_word) begin
            bus.mem_address <= bus.mem_address + 1'b1;
        end
    end

    // Next-state selection.
    always_comb begin
        state_nxt = state;
        case (state)
            DS_IDLE:   if (bus.start) state_nxt = DS_ADDR;
            DS_ADDR:   state_nxt = DS_LOAD;
            DS_LOAD:   state_nxt = DS_SEND;
            DS_SEND:   if (word_done) state_nxt = last_word ? DS_FINISH : DS_ADDR;
            DS_FINISH: state_nxt = DS_IDLE;
            default:   state_nxt = DS_IDLE;
        endcase
    end

    // Output decode; status bits are taken from the next state so that the
    // registered versions line up with the state they describe.
    always_comb begin
        sel_nxt   = (state_nxt != DS_IDLE);
        done_nxt  = (state_nxt == DS_FINISH);
        // RAM data has settled for a full cycle by the end of LOAD; the
        // serialiser captures it at that edge and never looks at it again.
        uart_load = (state == DS_LOAD);
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_tx_byte (
        .clk  (clk),
        .rst  (rst),
        .load (uart_load),
        .data (bus.mem_data),
        .tx   (bus.tx),
        .busy (uart_busy)
    );

endmodule
